// File: rtl/x_mem_2p_param.sv
// x_mem_2p_param
//   Simple dual-port memory with one write port and one read port.
//   WIDTH x DEPTH words. The array has no reset. After reset, and after each
//   i_clr pulse, a clear sequence writes zero to every word, one word per
//   clock. o_busy is high while the clear runs, and all user accesses are
//   ignored during that time.
//
//   The clear shares the single write port with user writes: the clear mux
//   comes first, then the masked user write. This keeps the array inferable
//   as block RAM.
//
// Ports
//   i_clk, i_nrst       clock, asynchronous active-low reset
//   i_clr               pulse: zero the whole array (ignored while busy)
//   o_busy              clear sequence running
//   i_we/i_waddr/i_wmask/i_wdata
//                       write port with a per-bit mask (1 = update bit)
//   i_re/i_raddr        read port
//   o_rdata/o_rvalid    read data and valid. With RD_REG=1 they are
//                       registered (1-cycle latency); with RD_REG=0 they
//                       are combinational.
//
// FSM
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_CLEAR | writing 0 to mem[cnt], one word per edge; o_busy=1
//   ST_IDLE  | normal access; i_clr restarts the clear from word 0

module x_mem_2p_param #(
    parameter int WIDTH     = 2,
    parameter int DEPTH     = 2048,
    parameter int AW        = $clog2(DEPTH),
    parameter bit RD_REG    = 1'b1,
    parameter bit WR_BYPASS = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_clr,
    output logic             o_busy,
    input  logic [AW-1:0]    i_waddr,
    input  logic             i_we,
    input  logic [WIDTH-1:0] i_wmask,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    input  logic             i_re,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_rvalid
);

    localparam logic [0:0]    ST_CLEAR = 1'b0;
    localparam logic [0:0]    ST_IDLE  = 1'b1;

    // The address compare uses one extra bit, so DEPTH=2**AW still compares
    // correctly.
    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);

    logic [0:0]       state;
    logic [AW-1:0]    cnt;
    logic             busy;

    logic [WIDTH-1:0] mem [DEPTH];

    logic             wr_ok;
    logic             rd_in_range;
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] merged;
    logic             rw_hit;

    assign busy   = (state == ST_CLEAR);
    assign o_busy = busy;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (cnt == LAST) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (i_clr) begin
                        state <= ST_CLEAR;
                        cnt   <= '0;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Array: a single write port. The clear takes priority; user writes
    // are masked per bit, and out-of-range writes are dropped.
    // ------------------------------------------------------------------
    assign wr_ok       = ~busy & i_we & ({1'b0, i_waddr} < DEPTH_W);
    assign rd_in_range = ({1'b0, i_raddr} < DEPTH_W);
    assign rd_word     = rd_in_range ? mem[i_raddr] : '0;

    always_ff @(posedge i_clk) begin
        if (busy) begin
            mem[cnt] <= '0;
        end else if (wr_ok) begin
            for (int b = 0; b < WIDTH; b++) begin
                if (i_wmask[b]) begin
                    mem[i_waddr][b] <= i_wdata[b];
                end
            end
        end
    end

    // The word as it will be after this edge's write, for the
    // same-address read-during-write case.
    assign merged = (rd_word & ~i_wmask) | (i_wdata & i_wmask);
    assign rw_hit = wr_ok & rd_in_range & (i_waddr == i_raddr);

    // ------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------
    generate
        if (RD_REG) begin : g_rd_reg
            logic [WIDTH-1:0] rdata_q;
            logic             rvalid_q;

            always_ff @(posedge i_clk or negedge i_nrst) begin
                if (!i_nrst) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= i_re & ~busy;
                    if (i_re & ~busy) begin
                        rdata_q <= (WR_BYPASS && rw_hit) ? merged : rd_word;
                    end
                end
            end

            assign o_rdata  = rdata_q;
            assign o_rvalid = rvalid_q;
        end else begin : g_rd_comb
            // A same-cycle write only becomes visible after the edge.
            assign o_rdata  = busy ? '0 : rd_word;
            assign o_rvalid = i_re & ~busy;
        end
    endgenerate

endmodule

// File: tb/tb_x_mem_2p_param.sv
module tb_x_mem_2p_param;

    // Shared clock and reset
    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    // Stimulus shared by the three 2048x2 instances:
    //   u_a: registered read, with bypass
    //   u_b: registered read, without bypass
    //   u_d: combinational read
    logic        clr, we, re;
    logic [10:0] waddr, raddr;
    logic [1:0]  wmask, wdata;
    logic        busy_a, rvalid_a, busy_b, rvalid_b, busy_d, rvalid_d;
    logic [1:0]  rdata_a, rdata_b, rdata_d;

    // Stimulus for the 1000x8 instance
    logic        c_clr, c_we, c_re;
    logic [9:0]  c_waddr, c_raddr;
    logic [7:0]  c_wmask, c_wdata, c_rdata;
    logic        c_busy, c_rvalid;

    x_mem_2p_param #(.WIDTH(2), .DEPTH(2048), .RD_REG(1'b1), .WR_BYPASS(1'b1)) u_a (
        .i_clk(clk), .i_nrst(nrst), .i_clr(clr), .o_busy(busy_a),
        .i_waddr(waddr), .i_we(we), .i_wmask(wmask), .i_wdata(wdata),
        .i_raddr(raddr), .i_re(re), .o_rdata(rdata_a), .o_rvalid(rvalid_a));

    x_mem_2p_param #(.WIDTH(2), .DEPTH(2048), .RD_REG(1'b1), .WR_BYPASS(1'b0)) u_b (
        .i_clk(clk), .i_nrst(nrst), .i_clr(clr), .o_busy(busy_b),
        .i_waddr(waddr), .i_we(we), .i_wmask(wmask), .i_wdata(wdata),
        .i_raddr(raddr), .i_re(re), .o_rdata(rdata_b), .o_rvalid(rvalid_b));

    x_mem_2p_param #(.WIDTH(2), .DEPTH(2048), .RD_REG(1'b0), .WR_BYPASS(1'b1)) u_d (
        .i_clk(clk), .i_nrst(nrst), .i_clr(clr), .o_busy(busy_d),
        .i_waddr(waddr), .i_we(we), .i_wmask(wmask), .i_wdata(wdata),
        .i_raddr(raddr), .i_re(re), .o_rdata(rdata_d), .o_rvalid(rvalid_d));

    x_mem_2p_param #(.WIDTH(8), .DEPTH(1000), .RD_REG(1'b1), .WR_BYPASS(1'b1)) u_c (
        .i_clk(clk), .i_nrst(nrst), .i_clr(c_clr), .o_busy(c_busy),
        .i_waddr(c_waddr), .i_we(c_we), .i_wmask(c_wmask), .i_wdata(c_wdata),
        .i_raddr(c_raddr), .i_re(c_re), .o_rdata(c_rdata), .o_rvalid(c_rvalid));

    // Reference model and scoreboard
    typedef struct packed {
        logic [1:0] a;
        logic [1:0] b;
    } exp_t;

    typedef struct {
        logic       we;
        logic [10:0] waddr;
        logic [1:0] wmask;
        logic [1:0] wdata;
        logic       re;
        logic [10:0] raddr;
        logic       chk;
        logic [1:0] exp_a;
        logic [1:0] exp_b;
    } vec_t;

    logic [1:0] mdl [2048];
    bit         mdl_busy;
    int         busy_left;
    exp_t       sb[$];
    logic [1:0] last_a, last_b;
    int         ncmp = 0;
    int         nbad = 0;
    vec_t       tbl [11];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle_in();
        clr = 1'b0; we = 1'b0; re = 1'b0;
        waddr = '0; raddr = '0; wmask = '0; wdata = '0;
    endtask

    task automatic mdl_zero();
        for (int i = 0; i < 2048; i++) mdl[i] = 2'b00;
    endtask

    // One clock cycle. Called at posedge+1 with the inputs already set.
    task automatic tick();
        exp_t       e;
        logic [1:0] old_w;
        logic       clr_s;
        #1;
        check("d_rdata", rdata_d, mdl_busy ? 32'd0 : 32'(mdl[raddr]));
        check("d_rvalid", rvalid_d, re & ~mdl_busy);
        clr_s = clr;
        if (!mdl_busy && re) begin
            old_w = mdl[raddr];
            e.b   = old_w;
            e.a   = (we && waddr == raddr) ? ((old_w & ~wmask) | (wdata & wmask)) : old_w;
            sb.push_back(e);
        end
        if (!mdl_busy && we) mdl[waddr] = (mdl[waddr] & ~wmask) | (wdata & wmask);
        @(posedge clk);
        if (mdl_busy) begin
            busy_left--;
            if (busy_left == 0) mdl_busy = 1'b0;
        end else if (clr_s) begin
            mdl_busy  = 1'b1;
            busy_left = 2048;
            mdl_zero();
        end
        #1;
        check("a_busy", busy_a, mdl_busy);
        check("b_busy", busy_b, mdl_busy);
        check("d_busy", busy_d, mdl_busy);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("a_rvalid", rvalid_a, 1);
            check("a_rdata", rdata_a, e.a);
            check("b_rvalid", rvalid_b, 1);
            check("b_rdata", rdata_b, e.b);
            last_a = e.a;
            last_b = e.b;
        end else begin
            check("a_rvalid_idle", rvalid_a, 0);
            check("a_rdata_hold", rdata_a, last_a);
            check("b_rvalid_idle", rvalid_b, 0);
            check("b_rdata_hold", rdata_b, last_b);
        end
    endtask

    // Leaves time at posedge+1 with reset just released.
    task automatic do_reset();
        nrst = 1'b0;
        idle_in();
        c_clr = 1'b0; c_we = 1'b0; c_re = 1'b0;
        c_waddr = '0; c_raddr = '0; c_wmask = '0; c_wdata = '0;
        mdl_busy  = 1'b1;
        busy_left = 2048;
        mdl_zero();
        sb.delete();
        last_a = '0;
        last_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy_a", busy_a, 1);
        check("rst_rdata_a", rdata_a, 0);
        check("rst_rvalid_a", rvalid_a, 0);
        check("rst_busy_c", c_busy, 1);
        check("rst_rvalid_c", c_rvalid, 0);
        check("rst_rdata_d", rdata_d, 0);
        nrst = 1'b1;
    endtask

    function automatic vec_t mk(logic w, int wa, int wm, int wd, logic r, int ra,
                                logic c, int ea, int eb);
        vec_t v;
        v.we = w; v.waddr = 11'(wa); v.wmask = 2'(wm); v.wdata = 2'(wd);
        v.re = r; v.raddr = 11'(ra); v.chk = c; v.exp_a = 2'(ea); v.exp_b = 2'(eb);
        return v;
    endfunction

    initial begin
        int n;

        tbl[0]  = mk(1,   5, 3, 3, 0,   0, 0, 0, 0);
        tbl[1]  = mk(1,   5, 1, 0, 0,   0, 0, 0, 0);
        tbl[2]  = mk(0,   0, 0, 0, 1,   5, 1, 2, 2);
        tbl[3]  = mk(0,   0, 0, 0, 1,   4, 1, 0, 0);
        tbl[4]  = mk(1, 100, 3, 1, 1, 100, 1, 1, 0);
        tbl[5]  = mk(0,   0, 0, 0, 1, 100, 1, 1, 1);
        tbl[6]  = mk(1,   7, 0, 3, 1,   7, 1, 0, 0);
        tbl[7]  = mk(1,   8, 3, 2, 1,   9, 1, 0, 0);
        tbl[8]  = mk(0,   0, 0, 0, 1,   8, 1, 2, 2);
        tbl[9]  = mk(1,   5, 2, 0, 1,   5, 1, 0, 2);
        tbl[10] = mk(0,   0, 0, 0, 1,   5, 1, 0, 0);

        do_reset();

        // Clear after reset: u_a runs 2048 cycles, u_c runs 1000
        for (int i = 0; i < 2048; i++) begin
            tick();
            if (i == 998 || i == 999) check("c_busy_len", c_busy, (i + 1) < 1000);
        end
        check("a_busy_done", busy_a, 0);

        // Every address reads zero
        for (int a = 0; a < 2048; a++) begin
            re = 1'b1; raddr = 11'(a);
            tick();
        end
        idle_in();
        tick();

        // Table: masks, bypass, read-during-write
        for (int i = 0; i < 11; i++) begin
            we = tbl[i].we; waddr = tbl[i].waddr; wmask = tbl[i].wmask; wdata = tbl[i].wdata;
            re = tbl[i].re; raddr = tbl[i].raddr;
            tick();
            if (tbl[i].chk) begin
                check($sformatf("tbl%0d_a", i), rdata_a, tbl[i].exp_a);
                check($sformatf("tbl%0d_b", i), rdata_b, tbl[i].exp_b);
            end
        end
        idle_in();

        // 1000x8: out-of-range write/read, last word, masked bypass
        c_we = 1; c_waddr = 10'd1000; c_wmask = 8'hFF; c_wdata = 8'hAA;
        tick();
        c_we = 0; c_re = 1; c_raddr = 10'd1000;
        tick();
        check("c_oor_rvalid", c_rvalid, 1);
        check("c_oor_rdata", c_rdata, 8'h00);
        c_re = 0; c_we = 1; c_waddr = 10'd999; c_wdata = 8'h55;
        tick();
        c_we = 0; c_re = 1; c_raddr = 10'd999;
        tick();
        check("c_999_rdata", c_rdata, 8'h55);
        c_we = 1; c_waddr = 10'd999; c_wmask = 8'hF0; c_wdata = 8'h0F;
        tick();
        check("c_bypass_mask", c_rdata, 8'h05);
        c_we = 0; c_re = 0;
        tick();
        check("c_rvalid_idle", c_rvalid, 0);
        check("c_rdata_hold", c_rdata, 8'h05);
        c_re = 1; c_raddr = 10'd998;
        tick();
        check("c_998_rdata", c_rdata, 8'h00);
        c_re = 0;

        // Fill 0..15, clear, then a second clr that must be ignored
        for (int a = 0; a < 16; a++) begin
            we = 1; waddr = 11'(a); wmask = 2'b11; wdata = 2'(a);
            tick();
        end
        idle_in();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n = busy_a ? 1 : 0;
        for (int j = 0; j < 4000; j++) begin
            if (!busy_a) break;
            idle_in();
            if (j == 9) clr = 1'b1;
            if (j >= 20 && j < 40) begin
                we = 1; re = 1; wmask = 2'b11; wdata = 2'b11;
                waddr = 11'($urandom_range(15, 0)); raddr = 11'($urandom_range(15, 0));
            end
            tick();
            if (busy_a) n++;
        end
        check("clr_busy_len", n, 2048);
        idle_in();
        for (int a = 0; a < 16; a++) begin
            re = 1; raddr = 11'(a);
            tick();
            check("clr_word_zero", rdata_a, 0);
        end
        idle_in();

        // Fresh clear: the no-bypass instance returns the pre-write word
        we = 1; waddr = 11'd100; wmask = 2'b11; wdata = 2'b01; re = 1; raddr = 11'd100;
        tick();
        check("nobyp_b", rdata_b, 0);
        check("byp_a", rdata_a, 1);
        idle_in();

        // Random traffic, with reset asserted partway through
        for (int i = 0; i < 1500; i++) begin
            we = 1'($urandom_range(1, 0)); re = 1'($urandom_range(1, 0));
            waddr = 11'($urandom_range(31, 0)); raddr = 11'($urandom_range(31, 0));
            wmask = 2'($urandom_range(3, 0)); wdata = 2'($urandom_range(3, 0));
            if (i == 1000) begin
                re = 1; raddr = 11'd3;
                tick();
                nrst = 1'b0;
                #1;
                check("mid_busy_d", busy_d, 1);
                check("mid_rdata_d", rdata_d, 0);
                check("mid_busy_a", busy_a, 1);
                check("mid_rvalid_a", rvalid_a, 0);
                check("mid_rdata_a", rdata_a, 0);
                @(posedge clk);
                #1;
                do_reset();
                repeat (2048) tick();
            end else begin
                tick();
            end
        end
        idle_in();
        tick();

        $display("test done: total=%0d bad=%0d", ncmp, nbad);
        $finish;
    end

endmodule

// File: doc/x_mem_2p_param.md
Name: x_mem_2p_param

Overview:
Parametrised simple-dual-port memory (one write port, one read port). It is the next-generation replacement for the fixed 2048x2 single-address store in the DAC sample and pattern path. Compared with the fixed store it adds:
- configurable width and depth
- bit-level write mask
- optional registered read with read-valid
- read-during-write bypass
- a clear sequencer in place of per-flop reset, so the array maps onto iCE40 block RAM

Parameters:
WIDTH, 2, data word width in bits (1..32)
DEPTH, 2048, number of words (2..8192; need not be a power of two)
AW, $clog2(DEPTH), address width (derived, not overridden)
RD_REG, 1, 1 = registered read (1-cycle latency); 0 = combinational read
WR_BYPASS, 1, only when RD_REG=1: 1 = same-address read-during-write returns the new word; 0 = returns the old word

Ports:
i_clk  in  1  clock
i_nrst  in  1  reset, asynchronous, active-low
i_clr  in  1  request to zero the whole array (single-cycle pulse)
o_busy  out  1  high while the clear sequence runs; accesses are ignored
i_waddr  in  AW  write address
i_we  in  1  write enable
i_wmask  in  WIDTH  per-bit write mask (1 = update bit)
i_wdata  in  WIDTH  write data
i_raddr  in  AW  read address
i_re  in  1  read enable
o_rdata  out  WIDTH  read data
o_rvalid  out  1  read data valid

Behaviour:
- Reset state and outputs:
  - Reset is i_nrst, asynchronous, active-low; clock is i_clk.
  - During reset: FSM=CLEAR, clear counter=0, o_busy=1, o_rdata=0, o_rvalid=0.
  - The array itself has no reset. Its contents are defined only by the clear sequence.
- FSM has two states, CLEAR and IDLE:
  - CLEAR: each rising edge writes 0 to mem[cnt] and increments cnt.
  - When cnt==DEPTH-1 is written, go to IDLE and deassert o_busy at that edge.
  - o_busy therefore falls on the DEPTH-th rising edge after reset release or after entry into CLEAR.
  - IDLE: i_clr=1 enters CLEAR on the next edge with cnt=0; o_busy rises at that edge.
  - i_clr during CLEAR is ignored; it neither restarts nor extends the sequence.
- Access gating:
  - While o_busy=1, i_we and i_re are ignored: no array write, o_rvalid=0.
  - In RD_REG=1 mode, o_rdata holds its last value.
- Write (IDLE, i_we=1, i_waddr<DEPTH):
  - At the edge, mem[a] <= (mem[a] & ~i_wmask) | (i_wdata & i_wmask).
  - i_wmask=0 means no change.
  - i_waddr>=DEPTH: the write is dropped silently.
- Read, RD_REG=1:
  - i_re=1 at edge N gives o_rdata=mem[i_raddr] and o_rvalid=1 after edge N.
  - o_rvalid is a single-cycle pulse per accepted read; back-to-back reads give continuous o_rvalid.
  - With no read, o_rdata holds its value and o_rvalid=0.
  - i_raddr>=DEPTH returns 0 with o_rvalid=1.
- Read, RD_REG=0:
  - o_rdata=mem[i_raddr] combinationally (0 if i_raddr>=DEPTH or o_busy=1).
  - o_rvalid = i_re & ~o_busy, combinational.
  - Same-cycle write is not visible until after the edge. This is bit-compatible with the fixed 2048x2 store when WIDTH=2, DEPTH=2048 and i_wmask='1.
- Read-during-write, same address, RD_REG=1:
  - WR_BYPASS=1: o_rdata is the merged new word.
  - WR_BYPASS=0: o_rdata is the pre-write word.
  - Different addresses never interact.
- Reset asserted mid-operation: the in-flight read is lost (o_rvalid=0) and the FSM restarts CLEAR from cnt=0.
- Implementation constraint: no logic may reset or fan out per-word enables across the whole array. Only the single write port (clear mux, then user write) is allowed, so the array infers as RAM.

Test Plan:
- Reset release, defaults -> o_busy=1 for exactly 2048 cycles, then 0. A read of every address returns 2'b00 with o_rvalid one cycle after i_re.
- Write 0x3 to addr 5, then write wdata=0x0 with wmask=0x1 to addr 5, then read addr 5 -> o_rdata=0x2. A read of addr 4 returns 0x0.
- RD_REG=1, WR_BYPASS=1: write 0x1 to addr 100 while reading addr 100 in the same cycle -> o_rdata=0x1. Repeat with WR_BYPASS=0 on a fresh clear -> o_rdata=0x0.
- DEPTH=1000, WIDTH=8: write 0xAA to addr 1000 then read addr 1000 -> o_rdata=0x00. Reading addr 999 after writing 0x55 -> 0x55. Clear lasts 1000 cycles.
- Fill addrs 0..15 with their index, pulse i_clr, pulse i_clr again 10 cycles later -> o_busy high for exactly DEPTH cycles from the first pulse. Writes and reads during busy are ignored (o_rvalid=0). All 16 words read 0 afterwards.
- RD_REG=0 random write/read traffic against a 2048x2 behavioural model -> o_rdata matches combinationally every cycle. Asserting i_nrst mid-traffic forces o_busy=1 and o_rdata=0 immediately.
